// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the multicycle CPU control sequencer.
//   state_e    - sequencer FSM states
//   OP_*       - opcode values of instr[15:13]
//   ALU_ADD    - ALU operation driven for every non-R-type instruction
package cpu_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OP_RTYPE   = 3'b000;
  localparam logic [2:0] OP_ADDI    = 3'b001;
  localparam logic [2:0] OP_LOAD    = 3'b010;
  localparam logic [2:0] OP_STORE   = 3'b011;
  localparam logic [2:0] OP_BEQ     = 3'b100;
  localparam logic [2:0] OP_JMP     = 3'b101;
  localparam logic [2:0] OP_HALT    = 3'b110;
  localparam logic [2:0] OP_ILLEGAL = 3'b111;

  localparam logic [2:0] ALU_ADD = 3'b000;

endpackage

// File: rtl/seq_decode.sv
// seq_decode: combinational opcode classifier for cpu_sequencer.
// Ports:
//   opcode     in  3 : instr[15:13]
//   is_load    out 1 : LOAD
//   is_store   out 1 : STORE
//   is_branch  out 1 : BEQ
//   is_jump    out 1 : JMP
//   uses_imm   out 1 : ALU B operand is the immediate (ADDI/LOAD/STORE)
//   writes_reg out 1 : instruction ends with a register write-back
//   is_halt    out 1 : HALT
//   is_illegal out 1 : reserved opcode 111
module seq_decode
  import cpu_pkg::*;
(
  input  logic [2:0] opcode,
  output logic       is_load,
  output logic       is_store,
  output logic       is_branch,
  output logic       is_jump,
  output logic       uses_imm,
  output logic       writes_reg,
  output logic       is_halt,
  output logic       is_illegal
);

  always_comb begin
    // NOTE: every output gets a default before the case so no latch is inferred.
    is_load    = 1'b0;
    is_store   = 1'b0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    uses_imm   = 1'b0;
    writes_reg = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (opcode)
      OP_RTYPE:   writes_reg = 1'b1;
      OP_ADDI: begin
        uses_imm   = 1'b1;
        writes_reg = 1'b1;
      end
      OP_LOAD: begin
        is_load    = 1'b1;
        uses_imm   = 1'b1;
        writes_reg = 1'b1;
      end
      OP_STORE: begin
        is_store = 1'b1;
        uses_imm = 1'b1;
      end
      OP_BEQ:     is_branch  = 1'b1;
      OP_JMP:     is_jump    = 1'b1;
      OP_HALT:    is_halt    = 1'b1;
      OP_ILLEGAL: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multicycle control sequencer for the 16-bit-instruction CPU.
// Owns PC and IR and walks each instruction through FETCH/DECODE/EXEC/MEM/WB.
// All outputs come straight from flops (Moore): each output flop is loaded
// with the value belonging to the state being entered.
// Optional feature: define CPU_SEQ_PERF_CNT_EN to add cycle_cnt/retire_cnt.
// Ports:
//   CLK, RESET        in      : divided clock, async active-high reset
//   start             in  1   : leave IDLE (ignored elsewhere)
//   imem_ready        in  1   : fetch done, imem_rdata valid this cycle
//   imem_rdata        in  16  : fetched instruction
//   dmem_ready        in  1   : data access done
//   zero              in  1   : ALU zero flag, used in EXEC for BEQ
//   pc                out PC_W: current instruction word address
//   instr             out 16  : instruction register
//   imem_req          out 1   : instruction fetch request
//   dmem_read/write   out 1   : data memory requests
//   alu_src           out 1   : ALU B operand = immediate
//   reg_write         out 1   : register file write enable (one cycle)
//   mem_to_reg        out 1   : write-back data from memory
//   alu_ctrl          out 3   : instr[12:10] for R-type, ALU_ADD otherwise
//   cycle_cnt         out 32  : (CPU_SEQ_PERF_CNT_EN) active cycles
//   retire_cnt        out 32  : (CPU_SEQ_PERF_CNT_EN) completed instructions
//   halted, illegal   out 1   : status
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 32,
  parameter int IMM_W = 10
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            start,
  input  logic            imem_ready,
  input  logic [15:0]     imem_rdata,
  input  logic            dmem_ready,
  input  logic            zero,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     instr,
  output logic            imem_req,
  output logic            dmem_read,
  output logic            dmem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic            mem_to_reg,
  output logic [2:0]      alu_ctrl,
`ifdef CPU_SEQ_PERF_CNT_EN
  output logic [31:0]     cycle_cnt,
  output logic [31:0]     retire_cnt,
`endif
  output logic            halted,
  output logic            illegal
);

  localparam logic [PC_W-1:0] PC_ONE = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            imem_req_q, imem_req_d;
  logic            dmem_read_q, dmem_read_d;
  logic            dmem_write_q, dmem_write_d;
  logic            alu_src_q, alu_src_d;
  logic            reg_write_q, reg_write_d;
  logic            mem_to_reg_q, mem_to_reg_d;
  logic [2:0]      alu_ctrl_q, alu_ctrl_d;
  logic            halted_q, halted_d;
  logic            illegal_q, illegal_d;

  logic is_load, is_store, is_branch, is_jump;
  logic uses_imm, writes_reg, is_halt, is_illegal;

  seq_decode u_decode (
    .opcode     (ir_q[15:13]),
    .is_load    (is_load),
    .is_store   (is_store),
    .is_branch  (is_branch),
    .is_jump    (is_jump),
    .uses_imm   (uses_imm),
    .writes_reg (writes_reg),
    .is_halt    (is_halt),
    .is_illegal (is_illegal)
  );

  logic [PC_W-1:0] imm_sext, pc_inc, pc_target;
  assign imm_sext  = {{(PC_W-IMM_W){ir_q[IMM_W-1]}}, ir_q[IMM_W-1:0]};
  assign pc_inc    = pc_q + PC_ONE;
  assign pc_target = pc_inc + imm_sext;  // wraps silently modulo 2^PC_W

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;

    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (is_halt) begin
          state_d = S_HALT;
        end else if (is_illegal) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_branch) begin
          pc_d    = zero ? pc_target : pc_inc;
          state_d = S_FETCH;
        end else if (is_jump) begin
          pc_d    = pc_target;
          state_d = S_FETCH;
        end else if (is_load || is_store) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (dmem_ready) begin
          if (is_load) begin
            state_d = S_WB;
          end else begin
            pc_d    = pc_inc;
            state_d = S_FETCH;
          end
        end
      end
      S_WB: begin
        pc_d    = pc_inc;
        state_d = S_FETCH;
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase

    // Output flops take the value of the state being entered. IR only changes
    // on FETCH->DECODE, so decoding ir_q is correct for EXEC/MEM/WB entries;
    // alu_ctrl follows the new IR so it is correct from DECODE onwards.
    imem_req_d   = (state_d == S_FETCH);
    alu_src_d    = (state_d == S_EXEC) && uses_imm;
    dmem_read_d  = (state_d == S_MEM) && is_load;
    dmem_write_d = (state_d == S_MEM) && is_store;
    reg_write_d  = (state_d == S_WB) && writes_reg;
    mem_to_reg_d = (state_d == S_WB) && is_load;
    halted_d     = (state_d == S_HALT);
    alu_ctrl_d   = (ir_d[15:13] == OP_RTYPE) ? ir_d[12:10] : ALU_ADD;
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q      <= S_IDLE;
      pc_q         <= '0;
      ir_q         <= '0;
      imem_req_q   <= 1'b0;
      dmem_read_q  <= 1'b0;
      dmem_write_q <= 1'b0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      halted_q     <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking so every flop samples the pre-edge values together.
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      imem_req_q   <= imem_req_d;
      dmem_read_q  <= dmem_read_d;
      dmem_write_q <= dmem_write_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      alu_ctrl_q   <= alu_ctrl_d;
      halted_q     <= halted_d;
      illegal_q    <= illegal_d;
    end
  end

  assign pc         = pc_q;
  assign instr      = ir_q;
  assign imem_req   = imem_req_q;
  assign dmem_read  = dmem_read_q;
  assign dmem_write = dmem_write_q;
  assign alu_src    = alu_src_q;
  assign reg_write  = reg_write_q;
  assign mem_to_reg = mem_to_reg_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign halted     = halted_q;
  assign illegal    = illegal_q;

`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;

  always_comb begin
    cycle_cnt_d  = cycle_cnt_q;
    retire_cnt_d = retire_cnt_q;
    if (state_q != S_IDLE && state_q != S_HALT) cycle_cnt_d = cycle_cnt_q + 32'd1;
    // An instruction retires when control returns to FETCH from a work state.
    if (state_d == S_FETCH &&
        (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB)) begin
      retire_cnt_d = retire_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      cycle_cnt_q  <= '0;
      retire_cnt_q <= '0;
    end else begin
      cycle_cnt_q  <= cycle_cnt_d;
      retire_cnt_q <= retire_cnt_d;
    end
  end

  assign cycle_cnt  = cycle_cnt_q;
  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// A table of hand-computed instruction vectors, hand-written halt/illegal/
// reset-abort sequences, and randomized instructions against an
// instruction-level reference model (phase list + next-PC arithmetic).
module tb_cpu_sequencer;
  import cpu_pkg::*;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        start = 1'b0;
  logic        imem_ready = 1'b0;
  logic [15:0] imem_rdata = 16'h0;
  logic        dmem_ready = 1'b0;
  logic        zero = 1'b0;
  logic [31:0] pc;
  logic [15:0] instr;
  logic        imem_req, dmem_read, dmem_write, alu_src, reg_write, mem_to_reg;
  logic [2:0]  alu_ctrl;
  logic        halted, illegal;
`ifdef CPU_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, retire_cnt;
`endif

  cpu_sequencer #(.PC_W(32), .IMM_W(10)) dut (
    .CLK        (CLK),
    .RESET      (RESET),
    .start      (start),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .dmem_ready (dmem_ready),
    .zero       (zero),
    .pc         (pc),
    .instr      (instr),
    .imem_req   (imem_req),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .alu_src    (alu_src),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .alu_ctrl   (alu_ctrl),
`ifdef CPU_SEQ_PERF_CNT_EN
    .cycle_cnt  (cycle_cnt),
    .retire_cnt (retire_cnt),
`endif
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 CLK = ~CLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // {imem_req, dmem_read, dmem_write, alu_src, reg_write, mem_to_reg, halted, illegal, alu_ctrl}
  function automatic logic [10:0] outv();
    return {imem_req, dmem_read, dmem_write, alu_src, reg_write, mem_to_reg,
            halted, illegal, alu_ctrl};
  endfunction

  function automatic logic [10:0] mk(input bit req, rd, wr, src, rw, m2r, hlt, ill,
                                     input logic [2:0] ac);
    return {req, rd, wr, src, rw, m2r, hlt, ill, ac};
  endfunction

  // ---------------- reference model ----------------
  typedef enum {PH_FW, PH_FL, PH_DEC, PH_EXE, PH_MW, PH_ML, PH_WB} ph_e;
  typedef struct {
    ph_e         kind;
    logic [10:0] exp;
  } phase_t;
  phase_t phases[$];

  logic [31:0] m_pc;
  logic [2:0]  m_ac;  // alu_ctrl implied by the instruction currently in IR

  function automatic logic [2:0] ref_alu_ctrl(input logic [15:0] ins);
    return (ins[15:13] == 3'b000) ? ins[12:10] : 3'b000;
  endfunction

  function automatic logic [31:0] ref_next_pc(input logic [31:0] p, input logic [15:0] ins,
                                              input logic z);
    int off;
    off = int'($signed(ins[9:0]));
    case (ins[15:13])
      3'b100:  return z ? p + 32'd1 + 32'(off) : p + 32'd1;
      3'b101:  return p + 32'd1 + 32'(off);
      default: return p + 32'd1;
    endcase
  endfunction

  function automatic int ref_cycles(input logic [2:0] op, input int iw, input int dw);
    int c;
    c = (iw + 1) + 2;                                   // fetch + decode + exec
    if (op == 3'b010 || op == 3'b011) c += dw + 1;      // memory phase
    if (op == 3'b000 || op == 3'b001 || op == 3'b010) c += 1;  // write-back
    return c;
  endfunction

  task automatic build_phases(input logic [15:0] ins, input int iw, input int dw,
                              input logic [2:0] prev_ac);
    logic [2:0] op, ac;
    bit ld, st;
    op = ins[15:13];
    ac = ref_alu_ctrl(ins);
    ld = (op == 3'b010);
    st = (op == 3'b011);
    phases.delete();
    for (int i = 0; i < iw; i++) phases.push_back('{PH_FW, mk(1,0,0,0,0,0,0,0,prev_ac)});
    phases.push_back('{PH_FL, mk(1,0,0,0,0,0,0,0,prev_ac)});
    phases.push_back('{PH_DEC, mk(0,0,0,0,0,0,0,0,ac)});
    phases.push_back('{PH_EXE, mk(0,0,0,(op == 3'b001) || ld || st,0,0,0,0,ac)});
    if (ld || st) begin
      for (int i = 0; i < dw; i++) phases.push_back('{PH_MW, mk(0,ld,st,0,0,0,0,0,ac)});
      phases.push_back('{PH_ML, mk(0,ld,st,0,0,0,0,0,ac)});
    end
    if (op == 3'b000 || op == 3'b001 || ld)
      phases.push_back('{PH_WB, mk(0,0,0,0,1,ld,0,0,ac)});
  endtask

  // Runs one instruction starting in FETCH; checks every cycle, the cycle
  // count until the next fetch, the resulting pc and the IR contents.
  task automatic run_instr(input string tag, input logic [15:0] ins, input logic z,
                           input int iw, input int dw, input bit noise,
                           input int exp_cycles, input logic [31:0] exp_pc);
    int  k;
    bit  left, done;
    ph_e kind;
    build_phases(ins, iw, dw, m_ac);
    k = 0; left = 0; done = 0;
    while (!done && k < 40) begin
      kind = (k < phases.size()) ? phases[k].kind : PH_DEC;
      imem_ready = (kind == PH_FL) ? 1'b1 : (kind == PH_FW) ? 1'b0 : (noise ? 1'($urandom) : 1'b0);
      imem_rdata = (kind == PH_FL) ? ins : 16'($urandom);
      dmem_ready = (kind == PH_ML) ? 1'b1 : (kind == PH_MW) ? 1'b0 : (noise ? 1'($urandom) : 1'b0);
      zero       = (kind == PH_EXE) ? z : (noise ? 1'($urandom) : 1'b0);
      start      = noise ? 1'($urandom) : 1'b0;
      if (k < phases.size())
        check($sformatf("%s cyc%0d outputs", tag, k), 64'(outv()), 64'(phases[k].exp));
      step();
      k++;
      if (!imem_req) left = 1;
      else if (left) done = 1;
    end
    imem_ready = 0; dmem_ready = 0; zero = 0; start = 0;
    check({tag, " completes"}, 64'(done), 64'(1));
    check({tag, " cycles"}, 64'(k), 64'(exp_cycles));
    check({tag, " pc"}, 64'(pc), 64'(exp_pc));
    check({tag, " instr"}, 64'(instr), 64'(ins));
    m_ac = ref_alu_ctrl(ins);
  endtask

  task automatic do_reset();
    RESET = 1;
    step();
    step();
    RESET = 0;
    m_pc = 0;
    m_ac = 0;
  endtask

  task automatic start_seq();
    start = 1;
    step();
    start = 0;
  endtask

  // Fetch+decode of HALT or illegal, then several cycles of start/ready noise.
  task automatic run_halt(input string tag, input logic [15:0] ins, input bit exp_ill);
    logic [31:0] pc0;
    pc0 = pc;
    imem_ready = 1; imem_rdata = ins;
    check({tag, " fetch"}, 64'(outv()), 64'(mk(1,0,0,0,0,0,0,0,m_ac)));
    step();
    imem_ready = 0;
    check({tag, " decode"}, 64'(outv()), 64'(mk(0,0,0,0,0,0,0,0,3'b000)));
    step();
    for (int i = 0; i < 5; i++) begin
      start = 1; imem_ready = 1'($urandom); dmem_ready = 1'($urandom); zero = 1'($urandom);
      check($sformatf("%s halted%0d", tag, i), 64'(outv()), 64'(mk(0,0,0,0,0,0,1,exp_ill,3'b000)));
      step();
    end
    start = 0; imem_ready = 0; dmem_ready = 0; zero = 0;
    check({tag, " pc held"}, 64'(pc), 64'(pc0));
  endtask

  typedef struct {
    logic [15:0] ins;
    logic        z;
    int          iw;
    int          dw;
    int          cyc;
    logic [31:0] pc_after;
  } vec_t;

  vec_t tbl[13];

  initial begin
    tbl[0]  = '{16'h2005, 1'b0, 0, 0, 4, 32'd1};    // ADDI
    tbl[1]  = '{16'h0C00, 1'b0, 0, 0, 4, 32'd2};    // R-type, alu 3
    tbl[2]  = '{16'h4000, 1'b0, 0, 3, 8, 32'd3};    // LOAD, 3 wait cycles
    tbl[3]  = '{16'h6000, 1'b0, 0, 0, 4, 32'd4};    // STORE
    tbl[4]  = '{16'hA000, 1'b0, 0, 0, 3, 32'd5};    // JMP +0
    tbl[5]  = '{16'h83FE, 1'b1, 0, 0, 3, 32'd4};    // BEQ -2 taken at pc 5
    tbl[6]  = '{16'hA000, 1'b0, 0, 0, 3, 32'd5};    // JMP +0
    tbl[7]  = '{16'h83FE, 1'b0, 0, 0, 3, 32'd6};    // BEQ -2 not taken
    tbl[8]  = '{16'h2005, 1'b0, 2, 0, 6, 32'd7};    // ADDI, 2 fetch waits
    tbl[9]  = '{16'hA1F8, 1'b0, 0, 0, 3, 32'd512};  // JMP +504
    tbl[10] = '{16'h6000, 1'b0, 0, 2, 6, 32'd513};  // STORE, 2 mem waits
    tbl[11] = '{16'h1C07, 1'b0, 0, 0, 4, 32'd514};  // R-type, alu 7
    tbl[12] = '{16'h4000, 1'b0, 1, 0, 6, 32'd515};  // LOAD, 1 fetch wait

    // Reset state and IDLE without start
    do_reset();
    check("reset outputs", 64'(outv()), 64'(0));
    check("reset pc", 64'(pc), 64'(0));
    check("reset instr", 64'(instr), 64'(0));
    imem_ready = 1; dmem_ready = 1;
    step(); step(); step();
    imem_ready = 0; dmem_ready = 0;
    check("idle holds", 64'(outv()), 64'(0));
`ifdef CPU_SEQ_PERF_CNT_EN
    check("idle cycle_cnt", 64'(cycle_cnt), 64'(0));
`endif

    // Table-driven vectors
    start_seq();
    for (int i = 0; i < 13; i++)
      run_instr($sformatf("tbl%0d", i), tbl[i].ins, tbl[i].z, tbl[i].iw, tbl[i].dw, 1'b1,
                tbl[i].cyc, tbl[i].pc_after);
`ifdef CPU_SEQ_PERF_CNT_EN
    begin
      int sum;
      sum = 0;
      for (int i = 0; i < 13; i++) sum += tbl[i].cyc;
      check("tbl retire_cnt", 64'(retire_cnt), 64'(13));
      check("tbl cycle_cnt", 64'(cycle_cnt), 64'(sum));
    end
`endif

    // PC wrap: 0 + 1 - 2 = all-ones, then JMP +0 wraps to 0
    do_reset();
    start_seq();
    run_instr("jmp to ffffffff", 16'hA3FE, 1'b0, 0, 0, 1'b0, 3, 32'hFFFF_FFFF);
    run_instr("jmp wrap", 16'hA000, 1'b0, 0, 0, 1'b0, 3, 32'h0000_0000);

    // HALT is sticky
    run_instr("pre-halt addi", 16'h2005, 1'b0, 0, 0, 1'b0, 4, 32'd1);
    run_halt("halt", 16'hC000, 1'b0);

    // Illegal opcode, then reset clears everything asynchronously
    do_reset();
    start_seq();
    run_halt("illegal", 16'hE000, 1'b1);
    #3 RESET = 1;
    #1;
    check("illegal reset outputs", 64'(outv()), 64'(0));
    check("illegal reset instr", 64'(instr), 64'(0));
    step();
    RESET = 0;

    // RESET during a STORE wait aborts immediately
    start_seq();
    run_instr("abort addi", 16'h2005, 1'b0, 0, 0, 1'b0, 4, 32'd1);
    imem_ready = 1; imem_rdata = 16'h6000;
    step();                         // DECODE
    imem_ready = 0;
    step();                         // EXEC
    step();                         // MEM, no ready
    check("store wait 1", 64'(dmem_write), 64'(1));
    step();
    check("store wait 2", 64'(dmem_write), 64'(1));
    #3 RESET = 1;
    #1;
    check("abort dmem_write", 64'(dmem_write), 64'(0));
    check("abort pc", 64'(pc), 64'(0));
    check("abort outputs", 64'(outv()), 64'(0));
`ifdef CPU_SEQ_PERF_CNT_EN
    check("abort cycle_cnt", 64'(cycle_cnt), 64'(0));
    check("abort retire_cnt", 64'(retire_cnt), 64'(0));
`endif
    dmem_ready = 1;
    step();
    step();
    check("held in reset", 64'(outv()), 64'(0));
    dmem_ready = 0;
    RESET = 0;
    m_pc = 0;
    m_ac = 0;

    // Randomized instructions against the reference model
    start_seq();
    for (int n = 0; n < 150; n++) begin
      logic [15:0] ins;
      logic        z;
      int          iw, dw;
      logic [31:0] nxt;
      ins = {3'($urandom_range(0, 5)), 13'($urandom)};
      z   = 1'($urandom);
      iw  = $urandom_range(0, 3);
      dw  = $urandom_range(0, 3);
      nxt = ref_next_pc(m_pc, ins, z);
      run_instr($sformatf("rnd%0d op%0d", n, ins[15:13]), ins, z, iw, dw, 1'b1,
                ref_cycles(ins[15:13], iw, dw), nxt);
      m_pc = nxt;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multicycle control sequencer for the 16-bit-instruction CPU datapath. Owns the PC and instruction register, walks each instruction through FETCH/DECODE/EXEC/MEM/WB, and drives the one-cycle enables for the register file, ALU source select, and data memory. Instruction and data memory are reached through req/ready handshakes. It sits between the top-level clock divider output and the datapath, replacing the free-running PC.

## Interface
- `PC_W`, default 32: PC width.
- `IMM_W`, default 10: immediate field width, instr[9:0].
- `CLK` in 1: divided system clock; all state updates on its rising edge.
- `RESET` in 1: asynchronous, active-high reset.
- `start` in 1: leaves IDLE; sampled only in IDLE.
- `imem_ready` in 1: fetch completes; `imem_rdata` is valid in the same cycle.
- `imem_rdata` in 16: fetched instruction.
- `dmem_ready` in 1: data access completes.
- `zero` in 1: ALU zero flag, valid during EXEC.
- `pc` out PC_W: current instruction address (word address).
- `instr` out 16: instruction register.
- `imem_req`, `dmem_read`, `dmem_write` out 1: memory requests.
- `alu_src`, `reg_write`, `mem_to_reg` out 1: datapath controls.
- `alu_ctrl` out 3: equals instr[12:10] for R-type; 3'b000 (add) otherwise.
- `halted`, `illegal` out 1: status.

## Operation
- Opcode is instr[15:13]:
  - 000 R-type
  - 001 ADDI
  - 010 LOAD
  - 011 STORE
  - 100 BEQ
  - 101 JMP
  - 110 HALT
  - 111 illegal.
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT.
- IDLE -> FETCH on `start`.
- FETCH:
  - `imem_req`=1 until `imem_ready`.
  - On ready: IR <= `imem_rdata`; go to DECODE.
- DECODE:
  - HALT -> HALT state.
  - 111 -> HALT state with `illegal` set.
  - Otherwise -> EXEC.
- EXEC:
  - `alu_src`=1 for ADDI/LOAD/STORE.
  - R-type/ADDI -> WB.
  - LOAD/STORE -> MEM.
  - BEQ: if `zero`, PC <= PC+1+sext(imm), else PC+1; then FETCH.
  - JMP: PC <= PC+1+sext(imm); then FETCH.
- MEM:
  - `dmem_read` (LOAD) or `dmem_write` (STORE) held until `dmem_ready`.
  - LOAD -> WB.
  - STORE: PC <= PC+1; then FETCH.
- WB:
  - `reg_write`=1 for exactly one cycle.
  - `mem_to_reg`=1 for LOAD.
  - PC <= PC+1; then FETCH.
- HALT is sticky; only RESET leaves it.
- PC arithmetic is modulo 2^PC_W; wrap from all-ones to 0 is silent.
- sext replicates instr[9] into the upper bits.

## Timing
- Reset state:
  - state=IDLE.
  - pc=0, instr=0.
  - All control and status outputs 0.
- Outputs are decoded from registered state and IR (Moore); no combinational path from `zero`/ready to the enables, except the PC/IR update at the clock edge.
- Latency with zero-wait memory (ready in the first request cycle):
  - R-type/ADDI: 4 cycles.
  - LOAD: 5 cycles.
  - STORE: 4 cycles.
  - BEQ/JMP: 3 cycles.
- Each wait cycle on a ready input adds exactly one cycle.
- Requests stay asserted and stable while waiting; a ready input outside its matching state is ignored.
- RESET asserted mid-FETCH or mid-MEM aborts immediately; no write enable is asserted after reset assertion.
- `start` while not in IDLE is ignored.

## Configuration
- `CPU_SEQ_PERF_CNT_EN`: when defined, adds two outputs:
  - `cycle_cnt` (32): increments on every cycle outside IDLE and HALT.
  - `retire_cnt` (32): increments on entry to FETCH from any of EXEC, MEM, or WB (one per completed instruction).
  - Both wrap and both clear on RESET.
- When undefined: neither the ports nor the logic exist, and sequencing behaviour is identical.

## Structure
- Shared package `cpu_pkg`:
  - State enum.
  - Opcode constants (OP_RTYPE … OP_ILLEGAL).
  - ALU_ADD constant.
- One sub-module, `seq_decode`: combinational opcode -> {is_load, is_store, is_branch, is_jump, uses_imm, writes_reg, is_halt, is_illegal}.
- PC/IR registers and the FSM live in `cpu_sequencer`.

## Test plan
- Reset, then `start`, with zero-wait memory, ADDI (16'h2005): `imem_req` in cycle 1, `reg_write` pulses in cycle 4, pc=1 after WB.
- LOAD with `dmem_ready` delayed 3 cycles: `dmem_read` held 4 cycles, `mem_to_reg`=`reg_write`=1 for one cycle, 8 cycles total.
- BEQ imm=10'h3FE (−2) at pc=5: with `zero`=1 the next pc=4; with `zero`=0 the next pc=6.
- JMP at pc=32'hFFFF_FFFF with imm=0: pc wraps to 0.
- Opcode 111: `illegal`=`halted`=1, no enables asserted, `start` ignored; RESET clears all.
- RESET asserted during a STORE wait: `dmem_write` drops asynchronously, pc=0; with `CPU_SEQ_PERF_CNT_EN` defined, both counters read 0.
